sine_tone_sequencer: RTL and testbench

- Controller that sequences the registered sine lookup table for tone bursts feeding the symmetric pipelined FIR datapath.
- Replaces the free-running phase accumulator with a programmable phase step, sample-rate divider, burst length and amplitude shift.
- Delivers samples over a valid/ready handshake to the FIR input stage, with start/abort control and done/overrun status.

---
 rtl/sine_tone_sequencer.sv | 154 +++++++++++++++
 tb/tb_sine_tone_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_tone_sequencer.sv
// sine_tone_sequencer: drives a registered sine LUT at a programmable phase step and sample rate,
// scales each sample by an arithmetic shift and hands bursts to the FIR over valid/ready.
// Revision: 1.0
`default_nettype none

module sine_tone_sequencer #(
  parameter int PHASE_W = 10,
  parameter int DATA_W  = 24,
  parameter int LEN_W   = 16,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [3:0]         cfg_shift,
  output logic [PHASE_W-1:0] lut_addr,
  input  logic [DATA_W-1:0]  lut_data,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]         state;
  logic [2:0]         state_nxt;

  logic [PHASE_W-1:0] step_l;
  logic [LEN_W-1:0]   len_l;
  logic [DIV_W-1:0]   div_l;
  logic [3:0]         shift_l;
  logic [PHASE_W-1:0] phase;
  logic [LEN_W-1:0]   count;
  logic [DIV_W-1:0]   div_cnt;
  logic               pending;

  logic               run;
  logic               tick;
  logic               pend_clr;
  logic               accept;
  logic               start_go;
  logic [LEN_W-1:0]   count_inc;
  logic               last;

  assign run       = (state != S_IDLE) && (state != S_DONE);
  assign tick      = run && (div_cnt == div_l);
  assign pend_clr  = (state == S_WAIT) && pending;
  assign accept    = (state == S_HOLD) && sample_valid && sample_ready;
  assign start_go  = (state == S_IDLE) && start && !abort;
  assign count_inc = count + LEN_W'(1);
  assign last      = (count_inc == len_l);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nxt = (cfg_len == '0) ? S_DONE : S_WAIT;
        S_WAIT:    if (pending) state_nxt = S_FETCH;
        S_FETCH:   state_nxt = S_CAPTURE;
        S_CAPTURE: state_nxt = S_HOLD;
        S_HOLD:    if (accept) state_nxt = last ? S_DONE : S_WAIT;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = run;
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_l       <= '0;
      len_l        <= '0;
      div_l        <= '0;
      shift_l      <= '0;
      phase        <= '0;
      count        <= '0;
      div_cnt      <= '0;
      pending      <= 1'b0;
      lut_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (abort) begin
      sample_valid <= 1'b0;
      pending      <= 1'b0;
      div_cnt      <= '0;
    end else if (start_go) begin
      step_l  <= cfg_step;
      len_l   <= cfg_len;
      div_l   <= cfg_div;
      shift_l <= cfg_shift;
      // A zero-length burst goes straight to DONE and keeps the previous overrun status.
      if (cfg_len != '0) begin
        phase   <= '0;
        count   <= '0;
        div_cnt <= '0;
        pending <= 1'b0;
        overrun <= 1'b0;
      end
    end else begin
      if (run) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end
      // A tick landing while the WAIT state consumes the old one re-arms pending.
      if (tick) begin
        pending <= 1'b1;
        if (pending && !pend_clr) overrun <= 1'b1;
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
      if (pend_clr) begin
        lut_addr <= phase;
      end
      if (state == S_CAPTURE) begin
        sample_out   <= $signed(lut_data) >>> shift_l;
        sample_valid <= 1'b1;
        phase        <= phase + step_l;
      end
      if (accept) begin
        sample_valid <= 1'b0;
        count        <= count_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sine_tone_sequencer.sv
// tb_sine_tone_sequencer: scoreboard bench with a one-cycle-latency LUT model for sine_tone_sequencer.
// Revision: 1.0
`default_nettype none

module tb_sine_tone_sequencer;

  localparam int PHASE_W = 10;
  localparam int DATA_W  = 24;
  localparam int LEN_W   = 16;
  localparam int DIV_W   = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [PHASE_W-1:0] cfg_step = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [DIV_W-1:0]   cfg_div = '0;
  logic [3:0]         cfg_shift = '0;
  logic [PHASE_W-1:0] lut_addr;
  logic [DATA_W-1:0]  lut_data = '0;
  logic [DATA_W-1:0]  sample_out;
  logic               sample_valid;
  logic               sample_ready = 1'b0;
  logic               busy;
  logic               done;
  logic               overrun;

  sine_tone_sequencer #(
    .PHASE_W(PHASE_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_step(cfg_step), .cfg_len(cfg_len), .cfg_div(cfg_div), .cfg_shift(cfg_shift),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic lut_mode = 1'b0;
  always @(posedge clk) lut_data <= lut_mode ? 24'h800000 : {14'b0, lut_addr};

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0]  exp_q[$];
  logic [PHASE_W-1:0] addr_q[$];

  logic check_addr = 1'b0;
  logic check_period = 1'b0;
  logic check_done_lat = 1'b0;
  logic have_rise = 1'b0;
  logic prev_valid = 1'b0;
  int   last_rise = 0;
  int   acc_cyc = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  int   rise_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and times valid rises and done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_valid && !prev_valid) begin
        rise_cnt++;
        if (check_period && have_rise) check("valid_period", cyc - last_rise, 8);
        last_rise = cyc;
        have_rise = 1'b1;
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", exp_q.size(), 1);
        end else begin
          logic [DATA_W-1:0]  e;
          logic [PHASE_W-1:0] a;
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          check("sample", sample_out, e);
          if (check_addr) check("lut_addr", lut_addr, a);
        end
        acc_cnt++;
        acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (check_done_lat) check("done_lat", cyc - acc_cyc, 1);
      end
      prev_valid = sample_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic pulse_start(input logic [PHASE_W-1:0] st, input logic [LEN_W-1:0] ln,
                             input logic [DIV_W-1:0] dv, input logic [3:0] sh);
    @(posedge clk); #1;
    cfg_step = st; cfg_len = ln; cfg_div = dv; cfg_shift = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_burst(input logic [PHASE_W-1:0] st, input int ln);
    logic [PHASE_W-1:0] ph;
    ph = '0;
    for (int i = 0; i < ln; i++) begin
      exp_q.push_back({14'b0, ph});
      addr_q.push_back(ph);
      ph = ph + st;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!sample_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!sample_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic new_test;
    exp_q.delete(); addr_q.delete();
    acc_cnt = 0; done_cnt = 0; rise_cnt = 0; have_rise = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_lut_addr", lut_addr, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Basic burst
    new_test(); check_addr = 1'b1; check_period = 1'b1; check_done_lat = 1'b1;
    sample_ready = 1'b1;
    push_burst(10'd256, 4);
    pulse_start(10'd256, 16'd4, 16'd7, 4'd0);
    check("basic_busy", busy, 1);
    wait_done("basic", 100);
    @(negedge clk);
    check("basic_busy_after", busy, 0);
    check("basic_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_acc_cnt", acc_cnt, 4);
    check("basic_sb_empty", exp_q.size(), 0);
    check_done_lat = 1'b0;

    // Wrap-around: addresses 0, 768, 512, 256
    new_test();
    push_burst(10'd768, 4);
    pulse_start(10'd768, 16'd4, 16'd7, 4'd0);
    wait_done("wrap", 100);
    repeat (2) @(negedge clk);
    check("wrap_acc_cnt", acc_cnt, 4);
    check("wrap_sb_empty", exp_q.size(), 0);

    // Reset asserted in FETCH: WAIT for cycles 0..8, tick in cycle 7, FETCH in cycle 9
    new_test(); check_period = 1'b0;
    pulse_start(10'd256, 16'd2, 16'd7, 4'd0);
    repeat (9) @(posedge clk);
    #1;
    check("fetch_busy", busy, 1);
    check("pre_rst_sample", sample_out, 24'h000100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_lut_addr", lut_addr, 0);
    check("mid_rst_sample_out", sample_out, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_overrun", overrun, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Shift and sign: 0x800000 >>> 4
    new_test(); check_addr = 1'b0; lut_mode = 1'b1;
    exp_q.push_back(24'hF80000); addr_q.push_back('0);
    pulse_start(10'd256, 16'd1, 16'd7, 4'd4);
    wait_done("shift", 100);
    repeat (2) @(negedge clk);
    check("shift_acc_cnt", acc_cnt, 1);
    lut_mode = 1'b0;

    // Backpressure
    new_test(); check_addr = 1'b1;
    sample_ready = 1'b0;
    push_burst(10'd256, 3);
    pulse_start(10'd256, 16'd3, 16'd7, 4'd0);
    wait_valid("bp", 100);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!sample_valid || sample_out != 24'h0) bad++;
      end
      check("bp_stable", bad, 0);
    end
    check("bp_overrun", overrun, 1);
    @(posedge clk); #1;
    sample_ready = 1'b1;
    wait_done("bp", 200);
    repeat (2) @(negedge clk);
    check("bp_acc_cnt", acc_cnt, 3);
    check("bp_sb_empty", exp_q.size(), 0);
    check("bp_overrun_held", overrun, 1);

    // Abort in HOLD
    new_test();
    sample_ready = 1'b0;
    pulse_start(10'd256, 16'd4, 16'd3, 4'd0);
    wait_valid("abort", 100);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", sample_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_lut_addr", lut_addr, 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_accept", acc_cnt, 0);

    // Length zero
    new_test();
    sample_ready = 1'b1;
    pulse_start(10'd256, 16'd0, 16'd7, 4'd0);
    wait_done("len0", 10);
    repeat (4) @(negedge clk);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_no_valid", rise_cnt, 0);
    check("len0_busy", busy, 0);

    // Start while busy is ignored
    new_test(); check_period = 1'b1;
    push_burst(10'd256, 3);
    pulse_start(10'd256, 16'd3, 16'd7, 4'd0);
    repeat (3) @(posedge clk);
    pulse_start(10'd64, 16'd1, 16'd2, 4'd3);
    wait_done("ign", 200);
    repeat (2) @(negedge clk);
    check("ign_acc_cnt", acc_cnt, 3);
    check("ign_sb_empty", exp_q.size(), 0);
    check("ign_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
